// File: rtl/apb_svt_bridge_pkg.sv
// ----------------------------------------------------------------------------
// apb_svt_bridge_pkg
// Shared types for the registered APB decode bridge:
//   state_t - bridge FSM states (IDLE, SETUP, ACCESS, RESP)
//   idx_w() - width of the slave-index field for a given slave count
//   req_t   - captured upstream request (addr, wdata, strb, prot, write, idx)
// The request fields are sized for the widest legal APB configuration
// (32-bit address and data, 16 slaves). The bridge zero-extends into them
// and slices back out.
// ----------------------------------------------------------------------------
package apb_svt_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   localparam int REQ_ADDR_W = 32;
   localparam int REQ_DATA_W = 32;
   localparam int REQ_STRB_W = REQ_DATA_W / 8;
   localparam int REQ_IDX_W  = 4;

   // A single slave still gets a 1-bit index field so slicing stays legal.
   function automatic int idx_w(input int num_slaves);
      return (num_slaves <= 1) ? 1 : $clog2(num_slaves);
   endfunction

   typedef struct packed {
      logic [REQ_ADDR_W-1:0] addr;
      logic [REQ_DATA_W-1:0] wdata;
      logic [REQ_STRB_W-1:0] strb;
      logic [2:0]            prot;
      logic                  write;
      logic [REQ_IDX_W-1:0]  idx;
   } req_t;

endpackage

// File: rtl/apb_svt_addr_decode.sv
// ----------------------------------------------------------------------------
// apb_svt_addr_decode
// Combinational slave decode for the APB bridge.
// Ports:
//   paddr - address bits from SLV_ADDR_LSB upward (the bits below do not
//           take part in the decode)
//   idx   - slave-index field, paddr[SLV_ADDR_LSB +: IDXW]
//   hit   - index is in range and every address bit above the field is 0
// ----------------------------------------------------------------------------
module apb_svt_addr_decode
   import apb_svt_bridge_pkg::*;
#(
   parameter int  NUM_SLAVES   = 4,
   parameter int  ADDR_WIDTH   = 32,
   parameter int  SLV_ADDR_LSB = 12,
   localparam int IDXW         = idx_w(NUM_SLAVES)
) (
   input  logic [ADDR_WIDTH-1:SLV_ADDR_LSB] paddr,
   output logic [IDXW-1:0]                  idx,
   output logic                             hit
);

   localparam int UPPER_LSB = SLV_ADDR_LSB + IDXW;

   logic in_range;
   logic upper_zero;

   assign idx = paddr[SLV_ADDR_LSB +: IDXW];

   // With a power-of-two slave count every index value is populated, so
   // the range compare is dropped rather than left as a constant compare.
   generate
      if (NUM_SLAVES == (1 << IDXW)) begin : g_full_range
         assign in_range = 1'b1;
      end else begin : g_part_range
         assign in_range = (idx < IDXW'(NUM_SLAVES));
      end

      if (UPPER_LSB < ADDR_WIDTH) begin : g_upper
         assign upper_zero = (paddr[ADDR_WIDTH-1:UPPER_LSB] == '0);
      end else begin : g_no_upper
         assign upper_zero = 1'b1;
      end
   endgenerate

   assign hit = in_range & upper_zero;

endmodule

// File: rtl/apb_svt_decode_bridge.sv
// ----------------------------------------------------------------------------
// apb_svt_decode_bridge
// Registered APB bridge: one upstream master port, NUM_SLAVES downstream
// slave ports. Every request is captured in IDLE, replayed downstream as a
// SETUP/ACCESS pair, and the response is returned upstream for exactly one
// cycle in RESP. Addresses that miss the decode skip the downstream side
// and complete with SLVERR one cycle after setup.
//
// Optional feature (compile-time macro SVT_APB_BRIDGE_TIMEOUT_EN):
//   ACCESS is abandoned with SLVERR after TIMEOUT_CYCLES cycles without
//   pready from the selected slave. Without the macro ACCESS waits forever.
//
// Ports:
//   pclk, preset                 clock, async active-high reset
//   psel_m/penable_m/pwrite_m,
//   paddr_m/pwdata_m/pstrb_m/
//   pprot_m                      upstream request
//   prdata_m/pready_m/pslverr_m  upstream response
//   psel_s (one-hot)/penable_s/
//   pwrite_s/paddr_s/pwdata_s/
//   pstrb_s/pprot_s              downstream request
//   prdata_s (sliced per slave)/
//   pready_s/pslverr_s           downstream responses
// ----------------------------------------------------------------------------
module apb_svt_decode_bridge
   import apb_svt_bridge_pkg::*;
#(
   parameter int NUM_SLAVES     = 4,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int SLV_ADDR_LSB   = 12,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                             pclk,
   input  logic                             preset,
   // upstream
   input  logic                             psel_m,
   input  logic                             penable_m,
   input  logic                             pwrite_m,
   input  logic [ADDR_WIDTH-1:0]            paddr_m,
   input  logic [DATA_WIDTH-1:0]            pwdata_m,
   input  logic [DATA_WIDTH/8-1:0]          pstrb_m,
   input  logic [2:0]                       pprot_m,
   output logic [DATA_WIDTH-1:0]            prdata_m,
   output logic                             pready_m,
   output logic                             pslverr_m,
   // downstream
   output logic [NUM_SLAVES-1:0]            psel_s,
   output logic                             penable_s,
   output logic                             pwrite_s,
   output logic [ADDR_WIDTH-1:0]            paddr_s,
   output logic [DATA_WIDTH-1:0]            pwdata_s,
   output logic [DATA_WIDTH/8-1:0]          pstrb_s,
   output logic [2:0]                       pprot_s,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata_s,
   input  logic [NUM_SLAVES-1:0]            pready_s,
   input  logic [NUM_SLAVES-1:0]            pslverr_s
);

   localparam int IDXW   = idx_w(NUM_SLAVES);
   localparam int STRB_W = DATA_WIDTH / 8;

   // Reject configurations the request struct or decode cannot represent.
   generate
      if (ADDR_WIDTH > REQ_ADDR_W || DATA_WIDTH > REQ_DATA_W ||
          (DATA_WIDTH != 8 && DATA_WIDTH != 16 && DATA_WIDTH != 32) ||
          NUM_SLAVES < 1 || NUM_SLAVES > 16 || TIMEOUT_CYCLES < 1 ||
          SLV_ADDR_LSB + IDXW > ADDR_WIDTH) begin : g_bad_cfg
         $error("apb_svt_decode_bridge: unsupported parameter set");
      end
   endgenerate

   state_t                state;
   state_t                state_nxt;
   req_t                  req;
   logic [DATA_WIDTH-1:0] rsp_data;
   logic                  rsp_err;

   logic [IDXW-1:0]       dec_idx;
   logic                  dec_hit;
   logic                  setup_req;
   logic                  sel_rdy;
   logic                  sel_err;
   logic [DATA_WIDTH-1:0] sel_rdata;
   logic                  timed_out;

   // Only a true setup phase starts a transfer; a held access phase seen
   // in IDLE (e.g. right after RESP) is not a new request.
   assign setup_req = psel_m & ~penable_m;

   apb_svt_addr_decode #(
      .NUM_SLAVES   (NUM_SLAVES),
      .ADDR_WIDTH   (ADDR_WIDTH),
      .SLV_ADDR_LSB (SLV_ADDR_LSB)
   ) u_decode (
      .paddr (paddr_m[ADDR_WIDTH-1:SLV_ADDR_LSB]),
      .idx   (dec_idx),
      .hit   (dec_hit)
   );

   // Response of the slave named by the captured index; every other
   // slave's pready/pslverr/prdata is ignored.
   always_comb begin : p_sel_mux
      sel_rdy   = 1'b0;
      sel_err   = 1'b0;
      sel_rdata = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (req.idx == REQ_IDX_W'(i)) begin
            sel_rdy   = pready_s[i];
            sel_err   = pslverr_s[i];
            sel_rdata = prdata_s[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

`ifdef SVT_APB_BRIDGE_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] acc_cnt;

   // Counts ACCESS cycles already spent; SETUP restarts it for each transfer.
   always_ff @(posedge pclk or posedge preset) begin : p_acc_cnt
      if (preset) begin
         acc_cnt <= '0;
      end else if (state == SETUP) begin
         acc_cnt <= '0;
      end else if (state == ACCESS) begin
         acc_cnt <= acc_cnt + 1'b1;
      end
   end

   // Fires in the TIMEOUT_CYCLES-th ACCESS cycle if the slave is still busy.
   assign timed_out = (state == ACCESS) && !sel_rdy &&
                      (acc_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign timed_out = 1'b0;
`endif

   // FSM state register
   always_ff @(posedge pclk or posedge preset) begin : p_state
      if (preset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state; psel_m is not looked at outside IDLE, so a master that
   // drops it mid-transfer still sees the downstream transfer run to RESP.
   always_comb begin : p_next
      state_nxt = state;
      case (state)
         IDLE: begin
            if (setup_req) begin
               state_nxt = dec_hit ? SETUP : RESP;
            end
         end
         SETUP:  state_nxt = ACCESS;
         ACCESS: begin
            if (sel_rdy || timed_out) begin
               state_nxt = RESP;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request/response capture
   always_ff @(posedge pclk or posedge preset) begin : p_data
      if (preset) begin
         req      <= '0;
         rsp_data <= '0;
         rsp_err  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (setup_req) begin
                  req.addr  <= REQ_ADDR_W'(paddr_m);
                  req.wdata <= REQ_DATA_W'(pwdata_m);
                  req.strb  <= REQ_STRB_W'(pstrb_m);
                  req.prot  <= pprot_m;
                  req.write <= pwrite_m;
                  req.idx   <= REQ_IDX_W'(dec_idx);
                  // A miss goes straight to RESP with these values.
                  rsp_data  <= '0;
                  rsp_err   <= ~dec_hit;
               end
            end
            ACCESS: begin
               if (sel_rdy) begin
                  rsp_data <= req.write ? '0 : sel_rdata;
                  rsp_err  <= sel_err;
               end else if (timed_out) begin
                  rsp_data <= '0;
                  rsp_err  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // FSM outputs; depend only on flops, never on upstream inputs.
   always_comb begin : p_out
      psel_s    = '0;
      penable_s = 1'b0;
      pready_m  = 1'b0;
      pslverr_m = 1'b0;
      prdata_m  = '0;
      case (state)
         SETUP, ACCESS: begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
               psel_s[i] = (req.idx == REQ_IDX_W'(i));
            end
            penable_s = (state == ACCESS);
         end
         RESP: begin
            pready_m  = 1'b1;
            pslverr_m = rsp_err;
            prdata_m  = rsp_data;
         end
         default: ;
      endcase
   end

   // Request fields are held from capture until the next accepted setup.
   assign pwrite_s = req.write;
   assign paddr_s  = req.addr[ADDR_WIDTH-1:0];
   assign pwdata_s = req.wdata[DATA_WIDTH-1:0];
   assign pstrb_s  = req.strb[STRB_W-1:0];
   assign pprot_s  = req.prot;

endmodule

// File: tb/tb_apb_svt_decode_bridge.sv
// ----------------------------------------------------------------------------
// tb_apb_svt_decode_bridge
// Bench for apb_svt_decode_bridge at default parameters. A reactive slave
// model answers the selected slave after cfg_waits ACCESS cycles; the other
// slaves drive random noise that must be ignored. Expected latency, select,
// response data and error come from a transaction-level model of the
// bridge's rules. The timeout scenario is built only with
// SVT_APB_BRIDGE_TIMEOUT_EN.
// ----------------------------------------------------------------------------
module tb_apb_svt_decode_bridge;

   localparam int NS  = 4;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int SW  = DW / 8;
   localparam int TMO = 16;

   logic               pclk = 1'b0;
   logic               preset;
   logic               psel_m, penable_m, pwrite_m;
   logic [AW-1:0]      paddr_m;
   logic [DW-1:0]      pwdata_m;
   logic [SW-1:0]      pstrb_m;
   logic [2:0]         pprot_m;
   logic [DW-1:0]      prdata_m;
   logic               pready_m, pslverr_m;
   logic [NS-1:0]      psel_s;
   logic               penable_s, pwrite_s;
   logic [AW-1:0]      paddr_s;
   logic [DW-1:0]      pwdata_s;
   logic [SW-1:0]      pstrb_s;
   logic [2:0]         pprot_s;
   logic [NS*DW-1:0]   prdata_s;
   logic [NS-1:0]      pready_s, pslverr_s;

   int vectors = 0;
   int errors  = 0;

   // slave model configuration
   int            cfg_waits = 0;
   logic          cfg_err   = 1'b0;
   logic [DW-1:0] cfg_rdata = '0;
   logic [NS-1:0] noise_rdy = '0;
   logic [NS-1:0] noise_err = '0;
   logic [DW-1:0] noise_data = '0;
   int            wcnt = 0;

   always #5 pclk = ~pclk;

   apb_svt_decode_bridge #(
      .NUM_SLAVES     (NS),
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .SLV_ADDR_LSB   (12),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .pclk      (pclk),
      .preset    (preset),
      .psel_m    (psel_m),
      .penable_m (penable_m),
      .pwrite_m  (pwrite_m),
      .paddr_m   (paddr_m),
      .pwdata_m  (pwdata_m),
      .pstrb_m   (pstrb_m),
      .pprot_m   (pprot_m),
      .prdata_m  (prdata_m),
      .pready_m  (pready_m),
      .pslverr_m (pslverr_m),
      .psel_s    (psel_s),
      .penable_s (penable_s),
      .pwrite_s  (pwrite_s),
      .paddr_s   (paddr_s),
      .pwdata_s  (pwdata_s),
      .pstrb_s   (pstrb_s),
      .pprot_s   (pprot_s),
      .prdata_s  (prdata_s),
      .pready_s  (pready_s),
      .pslverr_s (pslverr_s)
   );

   // ACCESS cycles already completed by the current downstream transfer
   always @(posedge pclk) begin
      wcnt <= (penable_s && (psel_s != '0)) ? wcnt + 1 : 0;
   end

   always_comb begin
      pready_s  = '0;
      pslverr_s = '0;
      prdata_s  = '0;
      for (int i = 0; i < NS; i++) begin
         if (psel_s[i]) begin
            pready_s[i]            = penable_s && (wcnt >= cfg_waits);
            pslverr_s[i]           = cfg_err;
            prdata_s[i*DW +: DW]   = cfg_rdata;
         end else begin
            pready_s[i]            = noise_rdy[i];
            pslverr_s[i]           = noise_err[i];
            prdata_s[i*DW +: DW]   = noise_data;
         end
      end
   end

   // One complete upstream transfer; returns right after the RESP cycle
   // so that a following call starts back-to-back.
   task automatic do_xfer(input string name, input logic [31:0] addr,
                          input logic wr, input logic [31:0] wdata,
                          input int waits, input logic serr, input bit tmo,
                          input logic [31:0] rdata);
      bit            hit;
      int            idx;
      int            exp_rdy, exp_sel_cycles, exp_en;
      logic          exp_err;
      logic [31:0]   exp_data;
      logic [NS-1:0] exp_sel;
      logic [SW-1:0] strb;
      logic [2:0]    prot;
      logic [AW+DW+SW+3:0] exp_req, got_req;
      int            first_sel, first_en, first_rdy, sel_cycles;
      logic [NS-1:0] sel_val, rsp_sel;
      logic [31:0]   got_data;
      logic          got_err;

      // transaction-level model
      hit            = (addr >> 12) < NS;
      idx            = int'(addr >> 12);
      exp_sel        = hit ? NS'(1 << idx) : '0;
      exp_rdy        = !hit ? 1 : (tmo ? 2 + TMO : 3 + waits);
      exp_sel_cycles = !hit ? 0 : (tmo ? 1 + TMO : 2 + waits);
      exp_en         = hit ? 2 : -1;
      exp_err        = !hit || tmo || serr;
      exp_data       = (hit && !wr && !tmo) ? rdata : 32'h0;
      strb           = SW'($urandom);
      prot           = 3'($urandom);
      exp_req        = {addr, wdata, strb, prot, wr};

      cfg_waits  = tmo ? 1000000 : waits;
      cfg_err    = serr;
      cfg_rdata  = rdata;
      noise_rdy  = NS'($urandom);
      noise_err  = NS'($urandom);
      noise_data = $urandom;

      @(posedge pclk); #1;
      psel_m = 1'b1; penable_m = 1'b0; paddr_m = addr; pwrite_m = wr;
      pwdata_m = wdata; pstrb_m = strb; pprot_m = prot;
      @(negedge pclk);
      vectors++;
      if (pready_m !== 1'b0 || psel_s !== '0) begin
         errors++;
         $display("FAIL %s setup_cycle: pready_m=%b psel_s=%b, need 0/0", name, pready_m, psel_s);
      end

      first_sel = -1; first_en = -1; first_rdy = -1; sel_cycles = 0;
      sel_val = '0; rsp_sel = '0; got_data = '0; got_err = 1'b0; got_req = '0;
      for (int c = 1; c <= 60 && first_rdy < 0; c++) begin
         @(posedge pclk); #1;
         penable_m = 1'b1;
         @(negedge pclk);
         if (psel_s !== '0) begin
            sel_cycles++;
            if (first_sel < 0) begin
               first_sel = c;
               sel_val   = psel_s;
               got_req   = {paddr_s, pwdata_s, pstrb_s, pprot_s, pwrite_s};
            end
         end
         if (penable_s === 1'b1 && first_en < 0) first_en = c;
         if (pready_m === 1'b1) begin
            first_rdy = c;
            got_data  = prdata_m;
            got_err   = pslverr_m;
            rsp_sel   = psel_s;
         end
      end

      vectors++;
      if (first_rdy != exp_rdy) begin
         errors++;
         $display("FAIL %s pready_latency: got %0d need %0d", name, first_rdy, exp_rdy);
      end
      vectors++;
      if (first_sel != (hit ? 1 : -1) || sel_val !== exp_sel) begin
         errors++;
         $display("FAIL %s psel: at %0d = %b, need at %0d = %b", name, first_sel, sel_val,
                  hit ? 1 : -1, exp_sel);
      end
      vectors++;
      if (first_en != exp_en || sel_cycles != exp_sel_cycles) begin
         errors++;
         $display("FAIL %s penable/psel_len: en at %0d len %0d, need %0d len %0d", name,
                  first_en, sel_cycles, exp_en, exp_sel_cycles);
      end
      if (hit) begin
         vectors++;
         if (got_req !== exp_req) begin
            errors++;
            $display("FAIL %s downstream_req: got %h need %h", name, got_req, exp_req);
         end
      end
      vectors++;
      if (got_err !== exp_err || got_data !== exp_data) begin
         errors++;
         $display("FAIL %s response: err=%b data=%h, need err=%b data=%h", name, got_err,
                  got_data, exp_err, exp_data);
      end
      vectors++;
      if (rsp_sel !== '0) begin
         errors++;
         $display("FAIL %s resp_psel: got %b need 0", name, rsp_sel);
      end
   endtask

   task automatic go_idle();
      @(posedge pclk); #1;
      psel_m = 1'b0; penable_m = 1'b0;
   endtask

   task automatic test_reset();
      preset = 1'b1;
      psel_m = 1'b1; penable_m = 1'b0; pwrite_m = 1'b1; paddr_m = 32'h0000_2000;
      pwdata_m = 32'hFFFF_FFFF; pstrb_m = '1; pprot_m = 3'h7;
      repeat (3) @(negedge pclk);
      vectors++;
      if ({prdata_m, pready_m, pslverr_m, psel_s, penable_s, pwrite_s, paddr_s,
           pwdata_s, pstrb_s, pprot_s} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: psel_s=%b pready_m=%b paddr_s=%h, need all 0",
                  psel_s, pready_m, paddr_s);
      end
      psel_m = 1'b0;
      preset = 1'b0;
   endtask

   task automatic test_directed();
      do_xfer("wr_slv2", 32'h0000_2004, 1'b1, 32'hA5A5_0001, 0, 1'b0, 1'b0, 32'h1234_5678);
      go_idle();
      do_xfer("rd_slv1_w3", 32'h0000_1000, 1'b0, 32'h0, 3, 1'b0, 1'b0, 32'hDEAD_BEEF);
      go_idle();
      do_xfer("miss_upper", 32'h0001_0000, 1'b0, 32'h0, 0, 1'b0, 1'b0, 32'hCAFE_F00D);
      go_idle();
      do_xfer("rd_slv3_err", 32'h0000_3010, 1'b0, 32'h0, 1, 1'b1, 1'b0, 32'h0BAD_0BAD);
      go_idle();
   endtask

   task automatic test_back_to_back();
      do_xfer("b2b_0", 32'h0000_0040, 1'b0, 32'h0, 0, 1'b0, 1'b0, 32'h1111_2222);
      do_xfer("b2b_1", 32'h0000_3FFC, 1'b1, 32'h3333_4444, 2, 1'b0, 1'b0, 32'h5555_6666);
      do_xfer("b2b_miss", 32'h8000_1000, 1'b1, 32'h7777_8888, 0, 1'b0, 1'b0, 32'h0);
      do_xfer("b2b_2", 32'h0000_2100, 1'b0, 32'h0, 1, 1'b0, 1'b0, 32'h9999_AAAA);
      go_idle();
   endtask

   task automatic test_random();
      logic [31:0] addr;
      for (int n = 0; n < 24; n++) begin
         if ($urandom_range(0, 9) < 7)
            addr = ($urandom_range(0, NS - 1) << 12) | $urandom_range(0, 4095);
         else
            addr = $urandom | 32'h0000_4000;
         do_xfer("rand", addr, 1'($urandom), $urandom, int'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0), 1'b0, $urandom);
         if ($urandom_range(0, 1) == 1) go_idle();
      end
      go_idle();
   endtask

`ifdef SVT_APB_BRIDGE_TIMEOUT_EN
   task automatic test_timeout();
      do_xfer("timeout_slv0", 32'h0000_0008, 1'b0, 32'h0, 0, 1'b0, 1'b1, 32'hFEED_FACE);
      go_idle();
   endtask
`endif

   task automatic test_reset_mid_access();
      bit seen;
      cfg_waits = 1000; cfg_err = 1'b0; cfg_rdata = 32'h0;
      @(posedge pclk); #1;
      psel_m = 1'b1; penable_m = 1'b0; pwrite_m = 1'b0; paddr_m = 32'h0000_2000;
      @(posedge pclk); #1;
      penable_m = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge pclk);
         if (penable_s === 1'b1 && psel_s === 4'b0100) seen = 1'b1;
      end
      vectors++;
      if (!seen) begin
         errors++;
         $display("FAIL mid_reset_access: slave 2 ACCESS not reached, psel_s=%b", psel_s);
      end
      #1 preset = 1'b1;
      #1;
      vectors++;
      if ({prdata_m, pready_m, pslverr_m, psel_s, penable_s, pwrite_s, paddr_s,
           pwdata_s, pstrb_s, pprot_s} !== '0) begin
         errors++;
         $display("FAIL mid_reset_outputs: psel_s=%b penable_s=%b paddr_s=%h, need all 0",
                  psel_s, penable_s, paddr_s);
      end
      @(negedge pclk);
      psel_m = 1'b0; penable_m = 1'b0;
      preset = 1'b0;
      do_xfer("post_reset_wr0", 32'h0000_0010, 1'b1, 32'h0F0F_F0F0, 0, 1'b0, 1'b0, 32'h0);
      go_idle();
   endtask

   initial begin
      preset = 1'b1;
      psel_m = 1'b0; penable_m = 1'b0; pwrite_m = 1'b0;
      paddr_m = '0; pwdata_m = '0; pstrb_m = '0; pprot_m = '0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_random();
`ifdef SVT_APB_BRIDGE_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid_access();
      repeat (2) @(posedge pclk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
